// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run controller: sequencer state encoding and
// default parameter values.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReset = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } ctrl_state_e;

    localparam int unsigned DefResetCycles = 2;
    localparam int unsigned DefRunCycles   = 5;
    localparam int unsigned DefCntW        = 32;
    localparam bit          DefAutoStart   = 1'b1;
    localparam bit          DefHaltEn      = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and increment enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/core_run_controller.sv
// Reset/run sequencer for the single-cycle core: holds the core in reset, runs it
// until halt or budget expiry, and reports cycle/retire counts and end status.
module core_run_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = DefResetCycles,
    parameter int unsigned RUN_CYCLES   = DefRunCycles,
    parameter int unsigned CNT_W        = DefCntW,
    parameter bit          AUTO_START   = DefAutoStart,
    parameter bit          HALT_EN      = DefHaltEn
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             start,
    input  logic             halt_in,
    input  logic             retire,
    output logic             core_rst_l,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned      HoldW    = $clog2(RESET_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RunLimit = CNT_W'(RUN_CYCLES);

    ctrl_state_e      state_d, state_q;
    logic [HoldW-1:0] hold_d, hold_q;
    logic             core_rst_l_d, core_rst_l_q;
    logic             running_d, running_q;
    logic             done_d, done_q;
    logic             halted_d, halted_q;
    logic             timed_out_d, timed_out_q;
    logic             cnt_clr;
    logic [CNT_W-1:0] cycle_next;

    // Value cycle_count takes at this edge, so the budget check sees the counted cycle.
    assign cycle_next = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        halted_d    = halted_q;
        timed_out_d = timed_out_q;
        cnt_clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (AUTO_START || start) begin
                    state_d = StReset;
                    hold_d  = '0;
                end
            end
            StReset: begin
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StRun: begin
                if (HALT_EN && halt_in) begin
                    state_d  = StDone;
                    halted_d = 1'b1;
                end else if ((RUN_CYCLES != 0) && (cycle_next == RunLimit)) begin
                    state_d     = StDone;
                    timed_out_d = 1'b1;
                end
            end
            StDone: begin
                if (start) begin
                    state_d     = StReset;
                    hold_d      = '0;
                    halted_d    = 1'b0;
                    timed_out_d = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        core_rst_l_d = (state_d == StRun);
        running_d    = (state_d == StRun);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            core_rst_l_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_rst_l_q <= core_rst_l_d;
            running_q    <= running_d;
            done_q       <= done_d;
            halted_q     <= halted_d;
            timed_out_q  <= timed_out_d;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_cycle_cnt (
        .clk_i   (clk),
        .rst_ni  (rst_l),
        .clr_i   (cnt_clr),
        .inc_i   (state_q == StRun),
        .count_o (cycle_count)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_retire_cnt (
        .clk_i   (clk),
        .rst_ni  (rst_l),
        .clr_i   (cnt_clr),
        .inc_i   ((state_q == StRun) && retire),
        .count_o (retire_count)
    );

    assign core_rst_l = core_rst_l_q;
    assign running    = running_q;
    assign done       = done_q;
    assign halted     = halted_q;
    assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: vector table, directed corner sequences and a
// randomized run against a behavioural model, over four parameter sets.
module tb_core_run_controller;

    typedef struct {
        logic        rst_l, start, halt, retire;
        logic        core, run, done, halted, to;
        logic [31:0] cyc, ret;
    } vec_t;

    typedef struct {
        int     reset_cycles;
        int     run_cycles;
        longint cnt_max;
        bit     auto_start;
        bit     halt_en;
    } cfg_t;

    typedef struct {
        bit     idle;
        int     hold_left;
        bit     in_run;
        bit     fin;
        longint cyc;
        longint ret;
        bit     halted;
        bit     to;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_l_i[4], start_i[4], halt_i[4], retire_i[4];
    logic core_o[4], run_o[4], done_o[4], halt_o[4], to_o[4];
    logic [31:0] cyc0, ret0, cyc1, ret1, cyc3, ret3;
    logic [3:0]  cyc2, ret2;

    int n_cmp = 0;
    int n_err = 0;

    // 0: defaults, 1: unlimited budget, 2: 4-bit counters unlimited, 3: manual start
    core_run_controller u_def (
        .clk(clk), .rst_l(rst_l_i[0]), .start(start_i[0]), .halt_in(halt_i[0]),
        .retire(retire_i[0]), .core_rst_l(core_o[0]), .running(run_o[0]), .done(done_o[0]),
        .halted(halt_o[0]), .timed_out(to_o[0]), .cycle_count(cyc0), .retire_count(ret0)
    );
    core_run_controller #(.RUN_CYCLES(0)) u_inf (
        .clk(clk), .rst_l(rst_l_i[1]), .start(start_i[1]), .halt_in(halt_i[1]),
        .retire(retire_i[1]), .core_rst_l(core_o[1]), .running(run_o[1]), .done(done_o[1]),
        .halted(halt_o[1]), .timed_out(to_o[1]), .cycle_count(cyc1), .retire_count(ret1)
    );
    core_run_controller #(.RUN_CYCLES(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst_l(rst_l_i[2]), .start(start_i[2]), .halt_in(halt_i[2]),
        .retire(retire_i[2]), .core_rst_l(core_o[2]), .running(run_o[2]), .done(done_o[2]),
        .halted(halt_o[2]), .timed_out(to_o[2]), .cycle_count(cyc2), .retire_count(ret2)
    );
    core_run_controller #(.AUTO_START(1'b0)) u_man (
        .clk(clk), .rst_l(rst_l_i[3]), .start(start_i[3]), .halt_in(halt_i[3]),
        .retire(retire_i[3]), .core_rst_l(core_o[3]), .running(run_o[3]), .done(done_o[3]),
        .halted(halt_o[3]), .timed_out(to_o[3]), .cycle_count(cyc3), .retire_count(ret3)
    );

    function automatic logic [68:0] actual(input int i);
        logic [31:0] c, r;
        case (i)
            0: begin c = cyc0; r = ret0; end
            1: begin c = cyc1; r = ret1; end
            2: begin c = {28'd0, cyc2}; r = {28'd0, ret2}; end
            default: begin c = cyc3; r = ret3; end
        endcase
        return {core_o[i], run_o[i], done_o[i], halt_o[i], to_o[i], c, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic s, input logic h,
                         input logic rt);
        rst_l_i[i]  = r;
        start_i[i]  = s;
        halt_i[i]   = h;
        retire_i[i] = rt;
    endtask

    task automatic expect_out(input string name, input int i, input logic c, input logic ru,
                              input logic d, input logic ha, input logic t,
                              input logic [31:0] cy, input logic [31:0] re);
        logic [68:0] got, want;
        got  = actual(i);
        want = {c, ru, d, ha, t, cy, re};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s inst%0d: got core=%0b run=%0b done=%0b halt=%0b to=%0b cyc=%0d ret=%0d, want core=%0b run=%0b done=%0b halt=%0b to=%0b cyc=%0d ret=%0d",
                     name, i, got[68], got[67], got[66], got[65], got[64], got[63:32],
                     got[31:0], c, ru, d, ha, t, cy, re);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m = '{idle: 1'b1, hold_left: 0, in_run: 1'b0, fin: 1'b0, cyc: 0, ret: 0,
              halted: 1'b0, to: 1'b0};
        return m;
    endfunction

    function automatic model_t step(input model_t m, input cfg_t c, input logic r,
                                    input logic s, input logic h, input logic rt);
        model_t n;
        n = m;
        if (!r) begin
            n = model_reset();
        end else if (m.idle) begin
            if (c.auto_start || s) begin
                n.idle      = 1'b0;
                n.hold_left = c.reset_cycles;
            end
        end else if (m.hold_left > 0) begin
            n.hold_left = m.hold_left - 1;
            if (n.hold_left == 0) n.in_run = 1'b1;
        end else if (m.in_run) begin
            n.cyc = (m.cyc + 1 > c.cnt_max) ? c.cnt_max : m.cyc + 1;
            if (rt) n.ret = (m.ret + 1 > c.cnt_max) ? c.cnt_max : m.ret + 1;
            if (c.halt_en && h) begin
                n.in_run = 1'b0;
                n.fin    = 1'b1;
                n.halted = 1'b1;
            end else if (c.run_cycles != 0 && n.cyc == longint'(c.run_cycles)) begin
                n.in_run = 1'b0;
                n.fin    = 1'b1;
                n.to     = 1'b1;
            end
        end else if (m.fin && s) begin
            n           = model_reset();
            n.idle      = 1'b0;
            n.hold_left = c.reset_cycles;
        end
        return n;
    endfunction

    vec_t   vt[20];
    cfg_t   cfg[4];
    model_t mdl[4];

    initial begin
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 1'b0, 1'b0);

        // Defaults: timeout run, then restart and halt on the budget's last cycle.
        vt[0]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        vt[5]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        vt[6]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 2, 2};
        vt[7]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 3, 3};
        vt[8]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 4, 4};
        vt[9]  = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 5, 5};
        vt[10] = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 5, 5};
        vt[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[13] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vt[14] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        vt[15] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 2, 1};
        vt[16] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 3, 2};
        vt[17] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 4, 2};
        vt[18] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 5, 3};
        vt[19] = '{1, 0, 1, 0, 0, 0, 1, 1, 0, 5, 3};
        for (int k = 0; k < 20; k++) begin
            drive(0, vt[k].rst_l, vt[k].start, vt[k].halt, vt[k].retire);
            tick();
            expect_out($sformatf("vec%0d", k), 0, vt[k].core, vt[k].run, vt[k].done,
                       vt[k].halted, vt[k].to, vt[k].cyc, vt[k].ret);
        end

        // Unlimited budget, halt on the third run cycle.
        drive(1, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(1, 1'b1, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();
        expect_out("inf_run_entry", 1, 1, 1, 0, 0, 0, 0, 0);
        tick(); tick();
        expect_out("inf_run2", 1, 1, 1, 0, 0, 0, 2, 2);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        expect_out("inf_halt", 1, 0, 0, 1, 1, 0, 3, 3);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        expect_out("inf_halt_hold", 1, 0, 0, 1, 1, 0, 3, 3);

        // 4-bit counters saturate at 15.
        drive(2, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(2, 1'b1, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15 || k == 20)
                expect_out($sformatf("sat_k%0d", k), 2, 1, 1, 0, 0, 0, 15, 15);
        end

        // Manual start: idle until start, restart from DONE.
        drive(3, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(3, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        expect_out("man_idle", 3, 0, 0, 0, 0, 0, 0, 0);
        drive(3, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        expect_out("man_reset0", 3, 0, 0, 0, 0, 0, 0, 0);
        drive(3, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        expect_out("man_reset1", 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("man_run", 3, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        expect_out("man_timeout", 3, 0, 0, 1, 0, 1, 5, 5);
        drive(3, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        expect_out("man_restart", 3, 0, 0, 0, 0, 0, 0, 0);
        drive(3, 1'b1, 1'b0, 1'b0, 1'b1); tick(); tick();
        expect_out("man_run2", 3, 1, 1, 0, 0, 0, 0, 0);
        drive(3, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        expect_out("man_start_in_run", 3, 1, 1, 0, 0, 0, 4, 4);
        drive(3, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        expect_out("man_timeout2", 3, 0, 0, 1, 0, 1, 5, 5);

        // Reset pulse mid-run on the default instance.
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        expect_out("mid_rst0", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1); tick(); tick(); tick(); tick(); tick();
        expect_out("mid_run2", 0, 1, 1, 0, 0, 0, 2, 2);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();
        expect_out("mid_rerun", 0, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        expect_out("mid_timeout", 0, 0, 0, 1, 0, 1, 5, 5);

        // Randomized run against the behavioural model.
        cfg[0] = '{2, 5, 64'hFFFF_FFFF, 1'b1, 1'b1};
        cfg[1] = '{2, 0, 64'hFFFF_FFFF, 1'b1, 1'b1};
        cfg[2] = '{2, 0, 64'd15, 1'b1, 1'b1};
        cfg[3] = '{2, 5, 64'hFFFF_FFFF, 1'b0, 1'b1};
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                logic r, s, h, rt;
                r  = (n < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
                s  = ($urandom_range(0, 7) == 0);
                h  = ($urandom_range(0, 15) == 0);
                rt = 1'($urandom_range(0, 1));
                drive(i, r, s, h, rt);
                mdl[i] = step(mdl[i], cfg[i], r, s, h, rt);
            end
            tick();
            for (int i = 0; i < 4; i++)
                expect_out($sformatf("rand%0d", n), i, mdl[i].in_run, mdl[i].in_run,
                           mdl[i].fin, mdl[i].halted, mdl[i].to, 32'(mdl[i].cyc),
                           32'(mdl[i].ret));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_run_controller.md
Name: core_run_controller

Overview:
- Synthesizable reset/run sequencer for the single-cycle RISC-V core. Replaces the fixed hand-timed reset/run/finish stimulus with a parametrised controller.
- Holds the core in reset for a programmable number of cycles, then releases it. Runs it until a halt indication or a cycle budget expires.
- Counts run cycles and retired instructions, and reports done/halted/timed-out status.
- Sits between the top-level clk/rst_l and the core's reset input. Usable in benches and on FPGA.

Parameters:
- RESET_CYCLES, 2, cycles core_rst_l is held low in RESET; legal range >= 1.
- RUN_CYCLES, 5, run-cycle budget; 0 = unlimited (no timeout).
- CNT_W, 32, width of cycle_count and retire_count.
- AUTO_START, 1, 1 = leave IDLE automatically after rst_l release; 0 = wait for start.
- HALT_EN, 1, 1 = halt_in terminates the run; 0 = halt_in ignored.

Ports:
- clk  input  1  system clock, rising edge.
- rst_l  input  1  synchronous active-low reset.
- start  input  1  level; begin a run from IDLE (AUTO_START=0) or restart from DONE.
- halt_in  input  1  core halt indication (ebreak/ecall decode), sampled in RUN only.
- retire  input  1  one instruction retired this cycle.
- core_rst_l  output  1  registered active-low reset to the core.
- running  output  1  high while in RUN.
- done  output  1  sticky high in DONE.
- halted  output  1  run ended by halt_in.
- timed_out  output  1  run ended by budget expiry.
- cycle_count  output  CNT_W  cycles spent in RUN.
- retire_count  output  CNT_W  retire pulses seen in RUN.

Behaviour:
- Reset:
  - Reset is synchronous and active-low on clk. On any rising edge sampling rst_l=0: state=IDLE, core_rst_l=0, running=0, done=0, halted=0, timed_out=0, both counters=0.
  - This applies in every state, including mid-run.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RESET, RUN, DONE.
- IDLE:
  - Outputs: core_rst_l=0.
  - Transition to RESET, hold counter=0: at the first edge with rst_l=1 if AUTO_START=1; otherwise at an edge with start=1.
- RESET:
  - Outputs: core_rst_l=0.
  - The hold counter increments each edge.
  - After exactly RESET_CYCLES edges in RESET, transition to RUN with core_rst_l=1 and running=1 registered at that same edge.
- RUN, each edge:
  - cycle_count+1, saturating.
  - retire_count+1 if retire=1, saturating.
  - Exit priority:
    - HALT_EN=1 and halt_in=1: go to DONE with halted=1. The halt cycle is counted, and its retire is counted.
    - Else RUN_CYCLES!=0 and the incremented cycle_count==RUN_CYCLES: go to DONE with timed_out=1.
  - If halt and budget expiry occur on the same edge, halt wins: halted=1, timed_out=0.
  - start is ignored in RUN.
- DONE:
  - Outputs: core_rst_l=0 (core frozen), running=0, done=1. Counters and flags hold.
  - start=1 transitions to RESET, clearing counters, done, halted and timed_out at that edge.
- Timing with AUTO_START=1, where E0 = first edge sampling rst_l=1:
  - core_rst_l rises at E0+RESET_CYCLES.
  - On timeout, done rises at E0+RESET_CYCLES+RUN_CYCLES.
- Saturation: counters stick at 2^CNT_W-1 and never wrap. With RUN_CYCLES=0 the run continues at saturation until halt or reset.
- halt_in and retire are don't-care outside RUN.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the state encoding (IDLE=0, RESET=1, RUN=2, DONE=3, 2 bits);
  - default parameter constants.
- One sub-module, sat_counter: parametrised width, synchronous clear, increment enable, saturate at all-ones. Instantiated for cycle_count and retire_count.
- The hold counter is a local counter of width clog2(RESET_CYCLES+1).

Test Plan:
- Defaults, rst_l low 2 edges then high, halt_in=0, retire=1 every cycle -> core_rst_l rises at E0+2; done=1, timed_out=1 at E0+7; cycle_count=5; retire_count=5.
- RUN_CYCLES=0, halt_in pulsed on 3rd RUN cycle -> DONE at that edge; halted=1, timed_out=0, cycle_count=3; core_rst_l=0 on the next cycle.
- Defaults, halt_in=1 on 5th RUN cycle -> halted=1, timed_out=0, cycle_count=5.
- CNT_W=4, RUN_CYCLES=0, retire=1 continuously for 20 cycles -> both counters hold at 15 with no wrap.
- AUTO_START=0 -> stays in IDLE with core_rst_l=0 until start=1. After DONE, start=1 -> counters=0, done=0, and the full sequence repeats.
- rst_l driven low for 1 edge mid-RUN -> at that edge: IDLE, core_rst_l=0, all flags and counters 0. Sequence restarts after release.
